// File: rtl/riscv_mc_pkg.sv
// rtl/riscv_mc_pkg.sv - shared opcodes, state/ALUOp encodings and mux selects for the multicycle controller
package riscv_mc_pkg;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10
   } state_t;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'd0,
      ALUOP_SUB   = 2'd1,
      ALUOP_FUNCT = 2'd2
   } aluop_t;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;
   localparam logic [2:0] F3_BLT = 3'b100;
   localparam logic [2:0] F3_BGE = 3'b101;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCB_RS2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;

endpackage

// File: rtl/mc_controller_if.sv
// rtl/mc_controller_if.sv - instruction fields, flags and control lines between controller and datapath
interface mc_controller_if;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       Zero;
   logic       Menor;
   logic       MemReady;
   logic       AdrSrc;
   logic       IRWrite;
   logic       PCWrite;
   logic       RegWrite;
   logic       MemWrite;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ResultSrc;
   logic [1:0] ImmSrc;
   logic [2:0] ALUControl;
   logic       IllegalInstr;
   logic [3:0] State;

   modport master (
      input  op, funct3, funct7b5, Zero, Menor, MemReady,
      output AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, ALUSrcA, ALUSrcB,
             ResultSrc, ImmSrc, ALUControl, IllegalInstr, State
   );

   modport slave (
      output op, funct3, funct7b5, Zero, Menor, MemReady,
      input  AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, ALUSrcA, ALUSrcB,
             ResultSrc, ImmSrc, ALUControl, IllegalInstr, State
   );
endinterface

// File: rtl/mc_aludec.sv
// rtl/mc_aludec.sv - combinational ALUOp/funct decode into the ALU operation code
module mc_aludec
   import riscv_mc_pkg::*;
(
   input  aluop_t     aluop_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7b5_i,
   input  logic       op5_i,
   output logic [2:0] alu_control_o
);

   always_comb begin
      alu_control_o = ALU_ADD;
      case (aluop_i)
         ALUOP_SUB:   alu_control_o = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3_i)
               // funct7b5 only means sub for R-type; addi keeps imm[10] there
               3'b000:  alu_control_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control_o = ALU_SLT;
               3'b110:  alu_control_o = ALU_OR;
               3'b111:  alu_control_o = ALU_AND;
               default: alu_control_o = ALU_ADD;
            endcase
         end
         default:     alu_control_o = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle RISC-V control FSM with memory-ready stalls
module mc_controller
   import riscv_mc_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   mc_controller_if.master bus
);

   state_t     state_q, state_d;
   aluop_t     aluop;
   logic       ir_write, pc_write, reg_write, mem_write, illegal;
   logic       adr_src;
   logic [1:0] alu_src_a, alu_src_b, result_src, imm_src;
   logic [2:0] alu_control;

   function automatic logic branch_taken(input logic [2:0] f3, input logic zero, input logic menor);
      case (f3)
         F3_BEQ:  return zero;
         F3_BNE:  return !zero;
         F3_BLT:  return menor;
         F3_BGE:  return !menor;
         default: return 1'b0;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      illegal    = 1'b0;
      adr_src    = 1'b0;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_RS2;
      result_src = RES_ALUOUT;
      aluop      = ALUOP_ADD;
      case (state_q)
         S_FETCH: begin
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALURES;
            ir_write   = bus.MemReady;
            pc_write   = bus.MemReady;
            if (bus.MemReady) state_d = S_DECODE;
         end
         S_DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            case (bus.op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECUTER;
               OP_I:         state_d = S_EXECUTEI;
               OP_BR:        state_d = S_BRANCH;
               OP_JAL:       state_d = S_JAL;
               default: begin
                  state_d = S_FETCH;
                  illegal = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            state_d   = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            adr_src = 1'b1;
            if (bus.MemReady) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            result_src = RES_DATA;
            reg_write  = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWRITE: begin
            adr_src   = 1'b1;
            mem_write = 1'b1;
            if (bus.MemReady) state_d = S_FETCH;
         end
         S_EXECUTER: begin
            alu_src_a = SRCA_RS1;
            aluop     = ALUOP_FUNCT;
            state_d   = S_ALUWB;
         end
         S_EXECUTEI: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            aluop     = ALUOP_FUNCT;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a = SRCA_RS1;
            aluop     = ALUOP_SUB;
            pc_write  = branch_taken(bus.funct3, bus.Zero, bus.Menor);
            state_d   = S_FETCH;
         end
         S_JAL: begin
            // PC <- ALUOut (target from DECODE) while the ALU forms OldPC+4 for rd
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_FOUR;
            pc_write  = 1'b1;
            state_d   = S_ALUWB;
         end
         default: state_d = S_FETCH;
      endcase
   end

   always_comb begin
      case (bus.op)
         OP_LW, OP_I: imm_src = 2'b00;
         OP_SW:       imm_src = 2'b01;
         OP_BR:       imm_src = 2'b10;
         OP_JAL:      imm_src = 2'b11;
         default:     imm_src = 2'b00;
      endcase
   end

   mc_aludec u_aludec (
      .aluop_i       (aluop),
      .funct3_i      (bus.funct3),
      .funct7b5_i    (bus.funct7b5),
      .op5_i         (bus.op[5]),
      .alu_control_o (alu_control)
   );

   // Reset squashes every architectural write, even from a mid-stall state
   assign bus.IRWrite      = ir_write  & ~reset;
   assign bus.PCWrite      = pc_write  & ~reset;
   assign bus.RegWrite     = reg_write & ~reset;
   assign bus.MemWrite     = mem_write & ~reset;
   assign bus.IllegalInstr = illegal   & ~reset;
   assign bus.AdrSrc       = adr_src;
   assign bus.ALUSrcA      = alu_src_a;
   assign bus.ALUSrcB      = alu_src_b;
   assign bus.ResultSrc    = result_src;
   assign bus.ImmSrc       = imm_src;
   assign bus.ALUControl   = alu_control;
   assign bus.State        = state_q;

endmodule
